pipeline_hazard_controller: RTL and testbench

//  Sequences the 5-stage ARM pipeline (PC, IF/ID, control-unit mux, ID/EX, EX/MEM, MEM/WB).

---
 rtl/arm_pipe_pkg.sv | 25 ++
 rtl/forward_select.sv | 35 +++
 rtl/pipeline_hazard_controller.sv | 165 ++++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARM 5-stage pipeline hazard controller.
// Contents: FSM state encoding, operand-forwarding select codes, the PC
// register index and a small source-match helper.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  localparam logic [3:0] REG_PC = 4'd15;

  // True when an ID source register is actually read and names dst.
  function automatic logic src_hits(input logic use_src, input logic [3:0] src,
                                    input logic [3:0] dst);
    return use_src && (src == dst);
  endfunction

endpackage

// File: rtl/forward_select.sv
// Operand forwarding select for a single ID-stage source register.
// Ports:
//   src, use_src          source register and its "actually read" flag
//   ex_rd/ex_write        EX/MEM-bound ALU result (write already excludes loads)
//   mem_rd/mem_write      EX/MEM destination
//   wb_rd/wb_write        MEM/WB destination
//   sel                   00 RF, 01 EX, 10 MEM, 11 WB
module forward_select
  import arm_pipe_pkg::*;
(
  input  logic [3:0] src,
  input  logic       use_src,
  input  logic [3:0] ex_rd,
  input  logic       ex_write,
  input  logic [3:0] mem_rd,
  input  logic       mem_write,
  input  logic [3:0] wb_rd,
  input  logic       wb_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    // R15 is the PC and is never produced by a later pipeline stage.
    if (use_src && (src != REG_PC)) begin
      if (ex_write && (ex_rd == src))
        sel = FWD_EX;
      else if (mem_write && (mem_rd == src))
        sel = FWD_MEM;
      else if (wb_write && (wb_rd == src))
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for the 5-stage ARM pipeline.
// Detects load-use hazards, taken branches (resolved in ID) and data-memory
// wait states; drives PC / IF-ID enables, IF-ID flush, the control-unit
// bubble mux and the downstream hold; produces Rn/Rm/Rd forwarding selects
// and saturating stall / flush counters.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   id_rn/id_rm/id_rd, id_use_* ID sources and use flags
//   id_branch_taken            branch resolved taken in ID
//   ex_rd, ex_reg_write, ex_mem_to_reg   ID/EX destination info
//   mem_rd/mem_reg_write, wb_rd/wb_reg_write  later-stage destinations
//   mem_busy                   data memory not ready this cycle
//   pc_enable, if_id_enable, if_id_flush, cu_mux_select, pipe_hold  controls
//   fwd_a/fwd_b/fwd_c          forwarding selects for Rn/Rm/Rd
//   stall_count, flush_count   saturating performance counters
//
// state  | meaning
// RUN    | normal issue; may start a stall, freeze or flush
// BUBBLE | extra load-use bubbles after the first (LOAD_LAT > 1)
// FREEZE | data memory busy; ret_state holds the context to resume
module pipeline_hazard_controller
  import arm_pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic             id_branch_taken,
  input  logic [3:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_to_reg,
  input  logic [3:0]       mem_rd,
  input  logic [3:0]       wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             mem_busy,
  output logic             pc_enable,
  output logic             if_id_enable,
  output logic             if_id_flush,
  output logic             cu_mux_select,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int BW = 3;
  localparam logic [BW-1:0] BUB_LAST = BW'(LOAD_LAT - 1);

  state_t        state;
  state_t        ret_state;
  state_t        eff_state;
  logic [BW-1:0] bub_cnt;
  logic          lu;
  logic          stall_inc;
  logic          flush_inc;
  logic          ex_alu_write;

  assign lu = ex_mem_to_reg && ex_reg_write && (ex_rd != REG_PC) &&
              (src_hits(id_use_rn, id_rn, ex_rd) ||
               src_hits(id_use_rm, id_rm, ex_rd) ||
               src_hits(id_use_rd, id_rd, ex_rd));

  // Once memory is ready again, FREEZE behaves as the context it interrupted,
  // so a busy pulse stretches a stall by exactly its own width.
  assign eff_state = (state == FREEZE) ? ret_state : state;

  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b0;
    pipe_hold     = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;
    if (!reset) begin
      if (mem_busy) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        pipe_hold    = 1'b1;
      end else if ((eff_state == BUBBLE) || lu) begin
        // Load-use wins over a branch: the branch stays in ID and is
        // re-evaluated once the load result is available.
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        cu_mux_select = 1'b1;
        stall_inc     = 1'b1;
      end else if (id_branch_taken) begin
        if_id_flush = 1'b1;
        flush_inc   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      ret_state   <= RUN;
      bub_cnt     <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_inc && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_inc && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);

      if (mem_busy) begin
        state     <= FREEZE;
        ret_state <= eff_state;
      end else if (eff_state == BUBBLE) begin
        if (bub_cnt == BUB_LAST) begin
          state   <= RUN;
          bub_cnt <= '0;
        end else begin
          state   <= BUBBLE;
          bub_cnt <= bub_cnt + BW'(1);
        end
      end else if (lu && (LOAD_LAT > 1)) begin
        state   <= BUBBLE;
        bub_cnt <= BW'(1);
      end else begin
        state <= RUN;
      end
    end
  end

  // Forwarding is silenced during reset by masking the use flags.
  forward_select u_fwd_a (
    .src(id_rn), .use_src(id_use_rn && !reset),
    .ex_rd(ex_rd), .ex_write(ex_alu_write),
    .mem_rd(mem_rd), .mem_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_write(wb_reg_write),
    .sel(fwd_a)
  );

  forward_select u_fwd_b (
    .src(id_rm), .use_src(id_use_rm && !reset),
    .ex_rd(ex_rd), .ex_write(ex_alu_write),
    .mem_rd(mem_rd), .mem_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_write(wb_reg_write),
    .sel(fwd_b)
  );

  forward_select u_fwd_c (
    .src(id_rd), .use_src(id_use_rd && !reset),
    .ex_rd(ex_rd), .ex_write(ex_alu_write),
    .mem_rd(mem_rd), .mem_write(mem_reg_write),
    .wb_rd(wb_rd), .wb_write(wb_reg_write),
    .sel(fwd_c)
  );

  // A load in EX has no result yet, so it cannot be forwarded from EX.
  assign ex_alu_write = ex_reg_write && !ex_mem_to_reg;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller.
// Two instances share one input bus: d1 (LOAD_LAT=1, CNT_W=4) and
// d3 (LOAD_LAT=3, CNT_W=16); the one not under test is held in reset.
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst3;
  logic [3:0] id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd;
  logic       id_use_rn, id_use_rm, id_use_rd, id_branch_taken;
  logic       ex_reg_write, ex_mem_to_reg, mem_reg_write, wb_reg_write, mem_busy;

  logic       pc_enable1, if_id_enable1, if_id_flush1, cu_mux_select1, pipe_hold1;
  logic [1:0] fwd_a1, fwd_b1, fwd_c1;
  logic [3:0] stall_count1, flush_count1;
  logic       pc_enable3, if_id_enable3, if_id_flush3, cu_mux_select3, pipe_hold3;
  logic [1:0] fwd_a3, fwd_b3, fwd_c3;
  logic [15:0] stall_count3, flush_count3;

  pipeline_hazard_controller #(.LOAD_LAT(1), .CNT_W(4)) d1 (
    .clk(clk), .reset(rst1),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_busy(mem_busy),
    .pc_enable(pc_enable1), .if_id_enable(if_id_enable1), .if_id_flush(if_id_flush1),
    .cu_mux_select(cu_mux_select1), .pipe_hold(pipe_hold1),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .fwd_c(fwd_c1),
    .stall_count(stall_count1), .flush_count(flush_count1)
  );

  pipeline_hazard_controller #(.LOAD_LAT(3), .CNT_W(16)) d3 (
    .clk(clk), .reset(rst3),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_branch_taken(id_branch_taken),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
    .wb_reg_write(wb_reg_write), .mem_busy(mem_busy),
    .pc_enable(pc_enable3), .if_id_enable(if_id_enable3), .if_id_flush(if_id_flush3),
    .cu_mux_select(cu_mux_select3), .pipe_hold(pipe_hold3),
    .fwd_a(fwd_a3), .fwd_b(fwd_b3), .fwd_c(fwd_c3),
    .stall_count(stall_count3), .flush_count(flush_count3)
  );

  // Control word packing: {pc_enable, if_id_enable, if_id_flush, cu_mux_select, pipe_hold}
  localparam logic [4:0] IDLE   = 5'b11000;
  localparam logic [4:0] STALL  = 5'b00010;
  localparam logic [4:0] FREEZE = 5'b00001;
  localparam logic [4:0] FLUSH  = 5'b11100;

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;   // 0 controls, 1 forwarding, 2 counters
    logic [31:0] v;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int dut, input int kind);
    if (dut == 1) begin
      case (kind)
        0:       return {27'b0, pc_enable1, if_id_enable1, if_id_flush1, cu_mux_select1, pipe_hold1};
        1:       return {26'b0, fwd_a1, fwd_b1, fwd_c1};
        default: return {12'b0, stall_count1, 12'b0, flush_count1};
      endcase
    end else begin
      case (kind)
        0:       return {27'b0, pc_enable3, if_id_enable3, if_id_flush3, cu_mux_select3, pipe_hold3};
        1:       return {26'b0, fwd_a3, fwd_b3, fwd_c3};
        default: return {stall_count3, flush_count3};
      endcase
    end
  endfunction

  task automatic push(input int dut, input int kind, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc = cyc; e.dut = dut; e.kind = kind; e.v = v; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_o(input int dut, input logic [4:0] v, input string name);
    push(dut, 0, {27'b0, v}, name);
  endtask

  task automatic exp_f(input int dut, input logic [5:0] v, input string name);
    push(dut, 1, {26'b0, v}, name);
  endtask

  task automatic exp_c(input int dut, input int s, input int f, input string name);
    push(dut, 2, {s[15:0], f[15:0]}, name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rn = 4'd0; id_rm = 4'd0; id_rd = 4'd0;
    id_use_rn = 1'b0; id_use_rm = 1'b0; id_use_rd = 1'b0;
    id_branch_taken = 1'b0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_mem_to_reg = 1'b0;
    mem_rd = 4'd0; mem_reg_write = 1'b0;
    wb_rd = 4'd0; wb_reg_write = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic set_lu(input logic on);
    ex_mem_to_reg = on; ex_reg_write = on;
    ex_rd = on ? 4'd2 : 4'd0;
    id_rn = on ? 4'd2 : 4'd0;
    id_use_rn = on;
  endtask

  // Monitor: compares every expectation due in the current cycle at the falling edge.
  initial begin
    exp_t e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        total++;
        got = actual(e.dut, e.kind);
        if (e.cyc != cyc)
          $display("FAIL %s: expectation for cycle %0d reached monitor at cycle %0d", e.name, e.cyc, cyc);
        else if (got !== e.v)
          $display("FAIL %s: got %h expected %h", e.name, got, e.v);
        else
          passed++;
      end
    end
  end

  initial begin
    idle();
    rst1 = 1'b1; rst3 = 1'b1; mem_busy = 1'b1;

    // Reset held with mem_busy: outputs forced, counters cleared
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_o(1, IDLE, "rst_forced_d1");
      exp_o(3, IDLE, "rst_forced_d3");
      exp_c(1, 0, 0, "rst_cnt_d1");
      exp_c(3, 0, 0, "rst_cnt_d3");
    end
    rst1 = 1'b0; mem_busy = 1'b0;
    exp_o(1, IDLE, "run_after_rst");

    // Load-use, LOAD_LAT=1
    tick(); set_lu(1'b1);
    exp_o(1, STALL, "lu1_stall"); exp_c(1, 0, 0, "lu1_cnt_before");
    tick(); set_lu(1'b0);
    exp_o(1, IDLE, "lu1_release"); exp_c(1, 1, 0, "lu1_cnt");

    // Load-use, LOAD_LAT=3, with a one-cycle mem_busy pulse in stall cycle 2
    tick(); rst1 = 1'b1; rst3 = 1'b0;
    exp_o(3, IDLE, "l3_idle"); exp_c(3, 0, 0, "l3_cnt0");
    tick(); set_lu(1'b1);
    exp_o(3, STALL, "l3_c1");
    tick(); mem_busy = 1'b1;
    exp_o(3, FREEZE, "l3_c2_freeze"); exp_c(3, 1, 0, "l3_c2_cnt");
    tick(); mem_busy = 1'b0;
    exp_o(3, STALL, "l3_c3_resume"); exp_c(3, 1, 0, "l3_freeze_nocount");
    tick();
    exp_o(3, STALL, "l3_c4"); exp_c(3, 2, 0, "l3_c4_cnt");
    tick(); set_lu(1'b0);
    exp_o(3, IDLE, "l3_done"); exp_c(3, 3, 0, "l3_cnt");

    // Load-use with a simultaneous branch: no flush until the stall clears
    tick(); rst3 = 1'b1; rst1 = 1'b0;
    exp_o(1, IDLE, "br_idle"); exp_c(1, 0, 0, "br_cnt_cleared");
    tick(); set_lu(1'b1); id_branch_taken = 1'b1;
    exp_o(1, STALL, "br_lu_noflush");
    tick(); set_lu(1'b0);
    exp_o(1, FLUSH, "br_flush");
    tick(); id_branch_taken = 1'b0;
    exp_o(1, IDLE, "br_after"); exp_c(1, 1, 1, "br_cnts");

    // Forwarding priority and R15 exclusion
    tick();
    ex_rd = 4'd3; ex_reg_write = 1'b1; ex_mem_to_reg = 1'b0;
    mem_rd = 4'd3; mem_reg_write = 1'b1; wb_rd = 4'd3; wb_reg_write = 1'b1;
    id_rn = 4'd3; id_use_rn = 1'b0; id_rm = 4'd3; id_use_rm = 1'b1;
    id_rd = 4'd3; id_use_rd = 1'b1;
    exp_f(1, 6'b00_01_01, "fwd_ex"); exp_o(1, IDLE, "fwd_no_stall");
    tick(); ex_reg_write = 1'b0;
    exp_f(1, 6'b00_10_10, "fwd_mem");
    tick(); mem_reg_write = 1'b0;
    exp_f(1, 6'b00_11_11, "fwd_wb");
    tick();
    ex_reg_write = 1'b1; mem_reg_write = 1'b1;
    ex_rd = 4'd15; mem_rd = 4'd15; wb_rd = 4'd15;
    id_rn = 4'd15; id_use_rn = 1'b1; id_rm = 4'd15; id_rd = 4'd15;
    exp_f(1, 6'b00_00_00, "fwd_r15");
    tick(); ex_mem_to_reg = 1'b1;
    exp_o(1, IDLE, "lu_r15_ignored");

    // Counter saturation with CNT_W=4
    tick(); idle(); rst1 = 1'b1;
    tick(); rst1 = 1'b0;
    exp_c(1, 0, 0, "sat_start");
    set_lu(1'b1);
    repeat (20) tick();
    set_lu(1'b0);
    exp_o(1, IDLE, "sat_release"); exp_c(1, 15, 0, "sat_stall");

    // Reset forcing with hazard, busy and forwarding inputs active
    tick(); rst1 = 1'b1; set_lu(1'b1); mem_busy = 1'b1;
    mem_rd = 4'd2; mem_reg_write = 1'b1;
    exp_o(1, IDLE, "rst_forced_busy"); exp_f(1, 6'b00_00_00, "rst_fwd_forced");
    tick(); rst1 = 1'b0; idle();
    exp_c(1, 0, 0, "sat_cleared");

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      total++;
      $display("FAIL %s: never compared, got none expected %h", e.name, e.v);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
